// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmit arbiter
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ARB     = 3'd0,
        FETCH   = 3'd1,
        SEND    = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4
    } tx_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searches upward from ptr+1 with wrap-around
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotating the doubled vector puts requester ptr+1 at bit 0.
    assign dbl = {req, req} >> (ptr + 1'b1);
    assign rot = dbl[N-1:0];

    always_comb begin
        found = |req;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off} + (IW + 1)'(1);
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-atomic round-robin arbiter feeding one uarttx; FRAME_TIMEOUT_EN adds a mid-frame stall abort
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_wrsig,
    input  logic                      tx_idle,
    output logic                      busy,
    output logic [IDW-1:0]            grant_id,
    output logic                      abort_pulse
);

    tx_state_e          state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [BYTE_W-1:0]  data_q;
    logic               last_q;
    logic               pick_found;
    logic [IDW-1:0]     pick_idx;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_last;
    logic               accept;
    logic               timeout;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_data = req_data[i*BYTE_W +: BYTE_W];
                sel_last = req_last[i];
            end
        end
    end

    assign accept = (state_q == FETCH) && req_valid[grant_q] && tx_idle;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] stall_q;

    // Counts only while waiting in FETCH; any other state or an accept restarts it.
    always_ff @(posedge clk) begin
        if (!reset_n || state_q != FETCH || accept) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign timeout     = (state_q == FETCH) && !accept && (stall_q == TW'(TIMEOUT_CYC - 1));
    assign abort_pulse = reset_n && timeout;
`else
    assign timeout     = 1'b0;
    assign abort_pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ARB;
            ptr_q   <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            if (accept) begin
                data_q <= sel_data;
                last_q <= sel_last;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            ARB: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (accept) begin
                    state_d = SEND;
                end else if (timeout) begin
                    ptr_d   = grant_q;
                    state_d = ARB;
                end
            end
            SEND: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_idle) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_idle) begin
                    if (last_q) begin
                        ptr_d   = grant_q;
                        state_d = ARB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Strobes are gated by reset so a mid-frame reset stops the handshake at once.
    assign req_ready = (reset_n && accept) ? (NUM_REQ'(1) << grant_q) : '0;
    assign tx_wrsig  = reset_n && (state_q == SEND);
    assign tx_data   = data_q;
    assign busy      = (state_q != ARB);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int IW       = 2;
    localparam int BYTE_CYC = 6;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_wrsig;
    logic           tx_idle;
    logic           busy;
    logic [IW-1:0]  grant_id;
    logic           abort_pulse;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .IDW         (IW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_wrsig    (tx_wrsig),
        .tx_idle     (tx_idle),
        .busy        (busy),
        .grant_id    (grant_id),
        .abort_pulse (abort_pulse)
    );

    // uarttx stand-in: idle drops after an accepted wrsig and rises BYTE_CYC cycles later; ignores reset
    logic uidle = 1'b1;
    int   ucnt = 0;
    logic hold = 1'b0;
    assign tx_idle = uidle & ~hold;

    always @(posedge clk) begin
        if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) uidle <= 1'b1;
        end else if (tx_wrsig && uidle) begin
            uidle <= 1'b0;
            ucnt  <= BYTE_CYC;
        end
    end

    // requesters: per-requester byte FIFOs {last, data}
    logic [8:0] fmem [N][64];
    int   head [N] = '{default: 0};
    int   tail [N] = '{default: 0};
    logic pend [N] = '{default: 1'b0};

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*8 +: 8]    = fmem[i][head[i]][7:0];
                req_last[i]           = fmem[i][head[i]][8];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) pend[i] = req_ready[i] & req_valid[i];
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (!reset_n) head[i] = tail[i];
            else if (pend[i]) head[i] = head[i] + 1;
        end
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        fmem[i][tail[i]] = {l, d};
        tail[i] = tail[i] + 1;
    endtask

    // monitor
    logic [7:0]    log_d [$];
    logic [IW-1:0] log_g [$];
    int   viol_idle = 0;
    int   viol_ready = 0;
    int   busy_rises = 0;
    int   aborts = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (tx_wrsig === 1'b1) begin
            log_d.push_back(tx_data);
            log_g.push_back(grant_id);
            if (tx_idle !== 1'b1) viol_idle++;
        end
        if ((req_ready & ~(N'(1) << grant_id)) !== '0) viol_ready++;
        if (busy === 1'b1 && busy_prev === 1'b0) busy_rises++;
        busy_prev = busy;
        if (abort_pulse === 1'b1) aborts++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int base;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        base = log_d.size();
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input int n, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (log_d.size() >= base + n && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (log_d.size() >= base + n) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, 32'(ok), 32'd1);
    endtask

    task automatic chk_log(input string tag, input int k, input logic [7:0] d, input logic [IW-1:0] g);
        logic [7:0]    od = 8'hxx;
        logic [IW-1:0] og = 'x;
        if (log_d.size() > base + k) begin
            od = log_d[base + k];
            og = log_g[base + k];
        end
        chk($sformatf("%s_byte%0d", tag, k), 32'(od), 32'(d));
        chk($sformatf("%s_grant%0d", tag, k), 32'(og), 32'(g));
    endtask

    initial begin
        int lat;
        int rises0;
        int aborts0;

        // T1: reset state, idle requesters for 100 cycles
        do_reset();
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("idle_outputs", {23'd0, busy, tx_wrsig, abort_pulse, req_ready, grant_id}, 32'd0);
        end

        // T2: req0 3-byte frame 41 44 0D, latency to first wrsig
        push(0, 8'h41, 1'b0);
        push(0, 8'h44, 1'b0);
        push(0, 8'h0D, 1'b1);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (tx_wrsig === 1'b1) break;
        end
        chk("first_wrsig_latency", 32'(lat), 32'd2);
        wait_done(3, "t2");
        chk("t2_count", 32'(log_d.size() - base), 32'd3);
        chk_log("t2", 0, 8'h41, 2'd0);
        chk_log("t2", 1, 8'h44, 2'd0);
        chk_log("t2", 2, 8'h0D, 2'd0);
        chk("t2_busy_end", 32'(busy), 32'd0);

        // T3: req0..2 each send a 2-byte frame, all pending together
        do_reset();
        rises0 = busy_rises;
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
        push(2, 8'h30, 1'b0); push(2, 8'h31, 1'b1);
        wait_done(6, "t3");
        chk_log("t3", 0, 8'h10, 2'd0);
        chk_log("t3", 1, 8'h11, 2'd0);
        chk_log("t3", 2, 8'h20, 2'd1);
        chk_log("t3", 3, 8'h21, 2'd1);
        chk_log("t3", 4, 8'h30, 2'd2);
        chk_log("t3", 5, 8'h31, 2'd2);
        chk("t3_busy_rises", 32'(busy_rises - rises0), 32'd3);

        // T4: req3 and req0 arrive during req1's frame, req1 re-requests at once
        do_reset();
        push(1, 8'h50, 1'b0); push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b1);
        wait_bytes(1, "t4");
        push(3, 8'h70, 1'b1);
        push(0, 8'h60, 1'b1);
        push(1, 8'h53, 1'b1);
        wait_done(6, "t4");
        chk_log("t4", 0, 8'h50, 2'd1);
        chk_log("t4", 1, 8'h51, 2'd1);
        chk_log("t4", 2, 8'h52, 2'd1);
        chk_log("t4", 3, 8'h70, 2'd3);
        chk_log("t4", 4, 8'h60, 2'd0);
        chk_log("t4", 5, 8'h53, 2'd1);

        // T5: single-byte frame from req2 while uarttx reports busy for 50 cycles
        do_reset();
        hold = 1'b1;
        push(2, 8'h5A, 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("t5_held_off", {30'd0, tx_wrsig, |req_ready}, 32'd0);
        end
        chk("t5_busy_held", 32'(busy), 32'd1);
        chk("t5_grant_held", 32'(grant_id), 32'd2);
        hold = 1'b0;
        wait_done(1, "t5");
        chk("t5_count", 32'(log_d.size() - base), 32'd1);
        chk_log("t5", 0, 8'h5A, 2'd2);

`ifdef FRAME_TIMEOUT_EN
        // T6: req1 stalls mid-frame, aborts, pending req2 then served
        do_reset();
        aborts0 = aborts;
        push(1, 8'h30, 1'b0);
        push(2, 8'h31, 1'b1);
        wait_done(2, "t6");
        chk("t6_aborts", 32'(aborts - aborts0), 32'd1);
        chk("t6_count", 32'(log_d.size() - base), 32'd2);
        chk_log("t6", 0, 8'h30, 2'd1);
        chk_log("t6", 1, 8'h31, 2'd2);
`else
        // T6: req1 stalls mid-frame; grant is kept and req2 waits
        do_reset();
        aborts0 = aborts;
        push(1, 8'h80, 1'b0);
        wait_bytes(1, "t6");
        push(2, 8'h90, 1'b1);
        repeat (40) @(negedge clk);
        chk("t6_busy_stall", 32'(busy), 32'd1);
        chk("t6_grant_stall", 32'(grant_id), 32'd1);
        chk("t6_count_stall", 32'(log_d.size() - base), 32'd1);
        push(1, 8'h81, 1'b1);
        wait_done(3, "t6");
        chk_log("t6", 0, 8'h80, 2'd1);
        chk_log("t6", 1, 8'h81, 2'd1);
        chk_log("t6", 2, 8'h90, 2'd2);
        chk("t6_no_abort", 32'(aborts - aborts0), 32'd0);
`endif

        // T7: reset mid-frame drops the rest of the frame
        do_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        wait_bytes(1, "t7");
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t7_rst_strobes", {30'd0, tx_wrsig, |req_ready}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t7_count", 32'(log_d.size() - base), 32'd1);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_grant", 32'(grant_id), 32'd0);

        chk("wrsig_only_when_idle", 32'(viol_idle), 32'd0);
        chk("ready_only_to_grant", 32'(viol_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
